// File: rtl/vc_input_buffer_if.sv
// vc_input_buffer_if: link-side flit input, per-VC head/pop and credit/drop status bundle
interface vc_input_buffer_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] in_data;
  logic              in_vc;
  logic              in_valid;
  logic              vc0_pop;
  logic              vc1_pop;
  logic [DATA_W-1:0] vc0_data;
  logic              vc0_valid;
  logic [DATA_W-1:0] vc1_data;
  logic              vc1_valid;
  logic [1:0]        vc_full;
  logic [1:0]        credit_ret;
  logic              in_drop;
  logic [7:0]        drop_cnt;
  modport master (
    output in_data, in_vc, in_valid, vc0_pop, vc1_pop,
    input  vc0_data, vc0_valid, vc1_data, vc1_valid, vc_full, credit_ret, in_drop, drop_cnt
  );
  modport slave (
    input  in_data, in_vc, in_valid, vc0_pop, vc1_pop,
    output vc0_data, vc0_valid, vc1_data, vc1_valid, vc_full, credit_ret, in_drop, drop_cnt
  );
endinterface

// File: rtl/vc_input_buffer.sv
// vc_input_buffer: two-VC router input FIFOs with credit return; VC_DROP_CNT_EN adds a saturating drop counter
module vc_input_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input logic clk,
  input logic reset,
  vc_input_buffer_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  logic [1:0]        valid, full, push, pop, pop_req;
  logic [DATA_W-1:0] head [2];
  logic              drop;
  assign pop_req = {bus.vc1_pop, bus.vc0_pop};
  assign drop    = bus.in_valid && full[bus.in_vc];
  for (genvar v = 0; v < 2; v++) begin : g_vc
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [CNT_W-1:0]  cnt;
    assign valid[v] = cnt != '0;
    assign full[v]  = cnt == CNT_W'(DEPTH);
    assign push[v]  = bus.in_valid && bus.in_vc == 1'(v) && !full[v];
    assign pop[v]   = pop_req[v] && valid[v];
    assign head[v]  = valid[v] ? mem[rptr] : '0;
    // storage write; contents need no reset since the count gates the head
    always_ff @(posedge clk)
      if (push[v]) mem[wptr] <= bus.in_data;
    // pointers wrap naturally; count nets push against pop
    always_ff @(posedge clk)
      if (reset) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (push[v]) wptr <= wptr + 1'b1;
        if (pop[v]) rptr <= rptr + 1'b1;
        cnt <= cnt + CNT_W'(push[v]) - CNT_W'(pop[v]);
      end
  end
  // one credit per effective pop and a drop flag, both a cycle after the event
  always_ff @(posedge clk)
    if (reset) begin
      bus.credit_ret <= '0;
      bus.in_drop    <= 1'b0;
    end else begin
      bus.credit_ret <= pop;
      bus.in_drop    <= drop;
    end
`ifdef VC_DROP_CNT_EN
  logic [7:0] drop_cnt;
  // saturating count of discarded flits
  always_ff @(posedge clk)
    if (reset) drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  assign bus.drop_cnt = drop_cnt;
`else
  assign bus.drop_cnt = 8'd0;
`endif
  assign bus.vc0_data  = head[0];
  assign bus.vc1_data  = head[1];
  assign bus.vc0_valid = valid[0];
  assign bus.vc1_valid = valid[1];
  assign bus.vc_full   = full;
endmodule

// File: tb/tb_vc_input_buffer.sv
// tb_vc_input_buffer: random and directed stimulus against a queue-based model, checked by a scoreboard monitor
module tb_vc_input_buffer;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  vc_input_buffer_if #(.DATA_W(8)) bus();
  vc_input_buffer #(.DATA_W(8), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic       v0, v1, p0, p1, rst;
    logic [1:0] full, cr;
    logic       dr;
    logic [7:0] dc;
  } ev_t;
  ev_t  evq[$];
  ev_t  e, prev;
  logic [7:0] m0[$], m1[$], sb0[$], sb1[$];
  logic [7:0] dc = 0;
  int total = 0, bad = 0;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask
  // one cycle of stimulus; the model decides expectations from start-of-cycle occupancy
  task automatic cyc(logic vld, logic vc, logic [7:0] d, logic p0, logic p1, logic rst);
    ev_t x;
    int s0, s1;
    @(posedge clk);
    #2;
    bus.in_valid = vld; bus.in_vc = vc; bus.in_data = d;
    bus.vc0_pop = p0; bus.vc1_pop = p1; reset = rst;
    s0 = m0.size(); s1 = m1.size();
    x.v0 = s0 != 0; x.v1 = s1 != 0; x.p0 = p0; x.p1 = p1; x.rst = rst;
    x.full = {s1 == DEPTH, s0 == DEPTH};
    if (rst) begin
      m0.delete(); m1.delete();
      x.cr = 0; x.dr = 0; dc = 0;
    end else begin
      x.cr = {p1 && s1 > 0, p0 && s0 > 0};
      x.dr = vld && x.full[vc];
      if (x.cr[0]) void'(m0.pop_front());
      if (x.cr[1]) void'(m1.pop_front());
      if (vld && !x.full[vc]) begin
        if (vc) begin m1.push_back(d); sb1.push_back(d); end
        else begin m0.push_back(d); sb0.push_back(d); end
      end
`ifdef VC_DROP_CNT_EN
      if (x.dr && dc != 8'hFF) dc++;
`endif
    end
    x.dc = dc;
    evq.push_back(x);
  endtask
  // monitor: registered outputs against last cycle's expectation, heads against the scoreboard
  initial begin
    prev = '{default: 0};
    forever begin
      @(negedge clk);
      if (evq.size() != 0) begin
        e = evq.pop_front();
        chk("credit_ret", bus.credit_ret, prev.cr);
        chk("in_drop", bus.in_drop, prev.dr);
        chk("drop_cnt", bus.drop_cnt, prev.dc);
        chk("vc0_valid", bus.vc0_valid, e.v0);
        chk("vc1_valid", bus.vc1_valid, e.v1);
        chk("vc_full", bus.vc_full, e.full);
        chk("vc0_data", bus.vc0_data, (e.v0 && sb0.size() != 0) ? sb0[0] : 8'h00);
        chk("vc1_data", bus.vc1_data, (e.v1 && sb1.size() != 0) ? sb1[0] : 8'h00);
        if (e.rst) begin
          sb0.delete(); sb1.delete();
        end else begin
          if (e.p0 && e.v0 && sb0.size() != 0) void'(sb0.pop_front());
          if (e.p1 && e.v1 && sb1.size() != 0) void'(sb1.pop_front());
        end
        prev = e;
      end
    end
  end
  initial begin
    bus.in_valid = 0; bus.in_vc = 0; bus.in_data = 0; bus.vc0_pop = 0; bus.vc1_pop = 0;
    repeat (3) @(posedge clk);
    cyc(1, 0, 8'hA1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 8'(8'h10 + i), 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'h50 + i), 0, 0, 0);
    cyc(1, 0, 8'h55, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 0, 8'h61, 0, 0, 0);
    cyc(1, 1, 8'h62, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 8'(8'h70 + i), i > 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1'(i), 8'(8'h80 + i), 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 8'(8'h90 + i), 0, 0, 0);
    cyc(1, 0, 8'hEE, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(9) < 7, 1'($urandom), 8'($urandom),
          $urandom_range(9) < 4, $urandom_range(9) < 4, $urandom_range(199) == 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
